// File: rtl/switch_pkg.sv
// Shared types for the packet-switch schedulers.
// Holds the default port count, the port index type and the arbiter state encoding.
// Imported by every scheduler block and by benches that poke at their internals.
package switch_pkg;

  // Port count of the switch fabric this slice belongs to.
  localparam int NUM_PORTS_DEF = 4;

  // Index of one ingress port at the default port count.
  typedef logic [$clog2(NUM_PORTS_DEF)-1:0] port_idx_t;

  // Output arbiter states: waiting for a requester, or forwarding one packet.
  typedef enum logic {
    ARB_IDLE,
    ARB_XFER
  } arb_state_t;

endpackage : switch_pkg

// File: rtl/switch_out_arbiter_rr_pick.sv
// Rotating-priority encoder: finds the first set req bit scanning ptr, ptr+1, ... (mod NUM_PORTS).
// Purely combinational, zero latency.
// No handshake; found=0 and idx=0 when no request is set.
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam logic [IDX_W:0] N_WIDE = (IDX_W+1)'(NUM_PORTS);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester to ptr wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= N_WIDE) begin
        sum = sum - N_WIDE;
      end
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/switch_out_arbiter.sv
// Per-egress scheduler: packet-granular round-robin over NUM_PORTS requesters, watchdog on stalled owners.
// Grant one cycle after request; beats forwarded combinationally while owned; one bubble after each EOP.
// out_ready is returned combinationally to the owner only; non-owners always see in_ready=0.
module switch_out_arbiter
  import switch_pkg::*;
#(
  parameter int NUM_PORTS   = NUM_PORTS_DEF,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          in_req,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  input  logic [NUM_PORTS-1:0]          in_sop,
  input  logic [NUM_PORTS-1:0]          in_eop,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_sop,
  output logic                          out_eop,
  input  logic                          out_ready,
  output logic [NUM_PORTS-1:0]          grant,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [CNT_W-1:0]              pkt_count
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  // The counter only has to reach TIMEOUT_CYC-1; keep it one bit wide when the watchdog is off.
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  arb_state_t           state, state_nxt;
  logic [NUM_PORTS-1:0] grant_nxt;
  logic [IDX_W-1:0]     owner, owner_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [TO_W-1:0]      idle_cnt, idle_cnt_nxt;
  logic [CNT_W-1:0]     pkt_count_nxt;
  logic                 timeout_err_nxt;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     owner_inc;
  logic                 beat_acc;
  logic                 eop_acc;
  logic                 wd_fire;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req   (in_req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Egress mux: forward the owner's beat; grant is all-zero outside XFER so nothing leaks when idle.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (state == ARB_XFER && grant[i]) begin
        out_valid = in_valid[i];
        out_data  = in_data[i*DATA_W +: DATA_W];
        out_sop   = in_sop[i];
        out_eop   = in_eop[i];
      end
    end
  end

  // Return path: only the owner sees the sink's ready.
  always_comb begin
    in_ready = '0;
    if (state == ARB_XFER && out_ready) begin
      in_ready = grant;
    end
  end

  assign busy      = (state == ARB_XFER);
  assign beat_acc  = out_valid && out_ready;
  assign eop_acc   = beat_acc && out_eop;
  assign owner_inc = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  // Watchdog fires only on a cycle with no accepted beat, so an EOP on the last allowed cycle wins.
  assign wd_fire   = (TIMEOUT_CYC != 0) && (state == ARB_XFER) && !beat_acc && (idle_cnt == TO_LAST);

  // Next-state and register updates; everything holds unless a branch below says otherwise.
  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    owner_nxt       = owner;
    rr_ptr_nxt      = rr_ptr;
    idle_cnt_nxt    = idle_cnt;
    pkt_count_nxt   = pkt_count;
    timeout_err_nxt = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_nxt    = ARB_XFER;
          owner_nxt    = pick_idx;
          idle_cnt_nxt = '0;
          for (int i = 0; i < NUM_PORTS; i++) begin
            grant_nxt[i] = (pick_idx == IDX_W'(i));
          end
        end
      end
      ARB_XFER: begin
        if (eop_acc) begin
          state_nxt     = ARB_IDLE;
          grant_nxt     = '0;
          rr_ptr_nxt    = owner_inc;
          idle_cnt_nxt  = '0;
          pkt_count_nxt = pkt_count + 1'b1;
        end else if (wd_fire) begin
          state_nxt       = ARB_IDLE;
          grant_nxt       = '0;
          rr_ptr_nxt      = owner_inc;
          idle_cnt_nxt    = '0;
          timeout_err_nxt = 1'b1;
        end else if (beat_acc) begin
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State and bookkeeping registers with synchronous reset; a reset mid-packet drops the packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      pkt_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      owner       <= owner_nxt;
      rr_ptr      <= rr_ptr_nxt;
      idle_cnt    <= idle_cnt_nxt;
      pkt_count   <= pkt_count_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule : switch_out_arbiter

// File: tb/tb_switch_out_arbiter.sv
// Directed bench for switch_out_arbiter with a short watchdog and a narrow packet counter.
// Inputs change and outputs are sampled around the falling edge, away from the active edge.
// Each step compares against hand-derived values.
module tb_switch_out_arbiter;
  import switch_pkg::*;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int TO = 8;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    in_req, in_valid, in_sop, in_eop, in_ready;
  logic [NP*DW-1:0] in_data;
  logic             out_valid, out_sop, out_eop, out_ready;
  logic [DW-1:0]    out_data;
  logic [NP-1:0]    grant;
  logic             busy, timeout_err;
  logic [CW-1:0]    pkt_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  switch_out_arbiter #(
    .NUM_PORTS   (NP),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_req      (in_req),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_ready   (out_ready),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err),
    .pkt_count   (pkt_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat on port p (all other ports quiet); p < 0 silences every port.
  task automatic drive(input int p, input logic v, input logic [DW-1:0] d, input logic s, input logic e);
    in_valid = '0;
    in_sop   = '0;
    in_eop   = '0;
    in_data  = '0;
    for (int i = 0; i < NP; i++) begin
      if (i == p) begin
        in_valid[i]           = v;
        in_data[i*DW +: DW]   = d;
        in_sop[i]             = s;
        in_eop[i]             = e;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_req    = '0;
    out_ready = 1'b0;
    drive(-1, 1'b0, 8'h00, 1'b0, 1'b0);

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_rr", dut.rr_ptr, 0);
    rst = 1'b0;

    // ---- single request, 3-beat packet ----
    @(negedge clk);
    in_req = 4'b0001;
    #1 chk("t1_no_grant_yet", grant, 0);
    @(negedge clk);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy", busy, 1);
    out_ready = 1'b1;
    drive(0, 1'b1, 8'hA0, 1'b1, 1'b0);
    #1 chk("t1_b0_valid", out_valid, 1);
    chk("t1_b0_data", out_data, 8'hA0);
    chk("t1_b0_sop", out_sop, 1);
    chk("t1_b0_ready", in_ready, 4'b0001);
    @(negedge clk);
    drive(0, 1'b1, 8'hA1, 1'b0, 1'b0);
    #1 chk("t1_b1_data", out_data, 8'hA1);
    @(negedge clk);
    drive(0, 1'b1, 8'hA2, 1'b0, 1'b1);
    in_req = '0;
    #1 chk("t1_b2_data", out_data, 8'hA2);
    chk("t1_b2_eop", out_eop, 1);
    @(negedge clk);
    drive(-1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t1_end_grant", grant, 0);
    chk("t1_end_busy", busy, 0);
    chk("t1_end_pkt", pkt_count, 1);
    chk("t1_end_rr", dut.rr_ptr, 1);

    // ---- fairness from a fresh reset: all ports, 1-beat packets ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t2_rst_pkt", pkt_count, 0);
    chk("t2_rst_rr", dut.rr_ptr, 0);
    in_req   = 4'b1111;
    in_valid = 4'b1111;
    in_sop   = 4'b1111;
    in_eop   = 4'b1111;
    in_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_grant", grant, 1 << (k % 4));
      chk("t2_data", out_data, 8'hC0 + (k % 4));
      @(negedge clk);
      chk("t2_bubble", grant, 0);
    end
    in_req = '0;
    drive(-1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_pkt", pkt_count, 5);
    chk("t2_rr", dut.rr_ptr, 1);

    // ---- backpressure on owner port 2, ignored requests, repeated SOP ----
    in_req = 4'b0100;
    @(negedge clk);
    chk("t3_grant", grant, 4'b0100);
    in_req = 4'b1011;
    out_ready = 1'b1;
    drive(2, 1'b1, 8'hB0, 1'b1, 1'b0);
    #1 chk("t3_b0_ready", in_ready, 4'b0100);
    chk("t3_b0_data", out_data, 8'hB0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(2, 1'b1, 8'hB1, 1'b1, 1'b0);
    #1 chk("t3_stall_ready", in_ready, 4'b0000);
    chk("t3_stall_valid", out_valid, 1);
    chk("t3_grant_held", grant, 4'b0100);
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("t3_b1_ready", in_ready, 4'b0100);
    chk("t3_b1_data", out_data, 8'hB1);
    chk("t3_sop2_busy", busy, 1);
    @(negedge clk);
    out_ready = 1'b0;
    drive(2, 1'b1, 8'hB2, 1'b0, 1'b1);
    #1 chk("t3_stall2_ready", in_ready, 4'b0000);
    chk("t3_pkt_mid", pkt_count, 5);
    @(negedge clk);
    out_ready = 1'b1;
    in_req = '0;
    #1 chk("t3_b2_data", out_data, 8'hB2);
    chk("t3_b2_ready", in_ready, 4'b0100);
    @(negedge clk);
    drive(-1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_end_grant", grant, 0);
    chk("t3_end_pkt", pkt_count, 6);
    chk("t3_end_rr", dut.rr_ptr, 3);

    // ---- watchdog: port 1 granted, never sends ----
    in_req = 4'b0010;
    @(negedge clk);
    chk("t4_grant", grant, 4'b0010);
    in_req = '0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk("t4_no_tmo", timeout_err, 0);
      chk("t4_idle_cnt", dut.idle_cnt, k);
    end
    @(negedge clk);
    chk("t4_tmo", timeout_err, 1);
    chk("t4_grant0", grant, 0);
    chk("t4_busy", busy, 0);
    chk("t4_rr", dut.rr_ptr, 2);
    chk("t4_pkt", pkt_count, 6);
    @(negedge clk);
    chk("t4_tmo_pulse", timeout_err, 0);

    // ---- EOP accepted on the cycle the watchdog would fire ----
    in_req = 4'b0100;
    @(negedge clk);
    chk("t4b_grant", grant, 4'b0100);
    in_req = '0;
    repeat (7) @(negedge clk);
    chk("t4b_idle_cnt", dut.idle_cnt, 7);
    drive(2, 1'b1, 8'hE7, 1'b1, 1'b1);
    #1 chk("t4b_data", out_data, 8'hE7);
    @(negedge clk);
    drive(-1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4b_no_tmo", timeout_err, 0);
    chk("t4b_pkt", pkt_count, 7);
    chk("t4b_grant0", grant, 0);
    chk("t4b_rr", dut.rr_ptr, 3);

    // ---- reset after 2 of 5 beats ----
    in_req = 4'b1000;
    @(negedge clk);
    chk("t5_grant", grant, 4'b1000);
    in_req = '0;
    drive(3, 1'b1, 8'hD0, 1'b1, 1'b0);
    @(negedge clk);
    drive(3, 1'b1, 8'hD1, 1'b0, 1'b0);
    @(negedge clk);
    drive(3, 1'b1, 8'hD2, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_grant0", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_pkt", pkt_count, 0);
    chk("t5_rr", dut.rr_ptr, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_out_valid", out_valid, 0);
    rst = 1'b0;
    drive(-1, 1'b0, 8'h00, 1'b0, 1'b0);

    // ---- 16 packets: counter wraps to 0, pointer wraps 3 -> 0 ----
    in_req   = 4'b1111;
    in_valid = 4'b1111;
    in_sop   = 4'b1111;
    in_eop   = 4'b1111;
    in_data  = {8'h63, 8'h62, 8'h61, 8'h60};
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("t6_grant", grant, 1 << (k % 4));
      @(negedge clk);
      chk("t6_pkt", pkt_count, (k + 1) % 16);
      chk("t6_rr", dut.rr_ptr, (k + 1) % 4);
    end
    in_req = '0;
    drive(-1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_pkt_wrapped", pkt_count, 0);
    @(negedge clk);
    chk("t6_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_switch_out_arbiter
